ocp_slave_mem: RTL and testbench

OCP_SLAVE_MEM -- requirements
Module: ocp_slave_mem

---
 rtl/ocp_slave_mem.sv | 205 ++++++++++++++++++++
 tb/tb_ocp_slave_mem.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_slave_mem.sv
// Single-outstanding OCP slave in front of a small register memory.
// One request is in flight at a time: a command is taken in IDLE, its write
// beats are absorbed in WDATA or its read beats are returned in RRESP, and
// non-posted writes finish with a single response in WRESP.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command, s_cmd_accept high
// WDATA   | absorbing write beats, s_data_accept high
// RRESP   | presenting read beats until the last one is accepted
// WRESP   | presenting the single write response until accepted
module ocp_slave_mem #(
    parameter int TAGI_WIDTH = 5,
    parameter int INFO_WIDTH = 4,
    parameter int BLEN_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              m_cmd,
    input  logic [ADDR_WIDTH-1:0]   m_addr,
    input  logic [BLEN_WIDTH-1:0]   m_burst_length,
    input  logic [2:0]              m_burst_seq,
    input  logic [DATA_WIDTH/8-1:0] m_byteen,
    input  logic [TAGI_WIDTH-1:0]   m_tagid,
    input  logic [INFO_WIDTH-1:0]   m_req_info,
    input  logic [DATA_WIDTH-1:0]   m_data,
    input  logic [DATA_WIDTH/8-1:0] m_data_byteen,
    input  logic                    m_data_last,
    input  logic [TAGI_WIDTH-1:0]   m_data_tagid,
    input  logic                    m_data_valid,
    input  logic                    m_resp_accept,
    output logic                    s_cmd_accept,
    output logic                    s_data_accept,
    output logic [DATA_WIDTH-1:0]   s_data,
    output logic [1:0]              s_resp,
    output logic                    s_resp_last,
    output logic [TAGI_WIDTH-1:0]   s_tagid
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int NBYTES   = DATA_WIDTH / 8;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [2:0] CMD_RDEX = 3'b011;
    localparam logic [2:0] CMD_RDL  = 3'b100;

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RRESP,
        ST_WRESP
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BLEN_WIDTH-1:0]   len_q, len_d;
    logic [BLEN_WIDTH-1:0]   beat_q, beat_d;
    logic [TAGI_WIDTH-1:0]   tag_q, tag_d;
    logic                    seq_err_q, seq_err_d;
    logic                    last_err_q, last_err_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    is_last;
    logic                    is_read_cmd;
    logic                    mem_we;

    // Request-side qualifiers and write-through data are not needed by this memory.
    logic unused_inputs;
    assign unused_inputs = ^{m_byteen, m_req_info, m_data_tagid};

    // Current beat address wraps naturally in ADDR_WIDTH bits.
    assign cur_addr     = addr_q + ADDR_WIDTH'(beat_q);
    assign is_last      = (beat_q == (len_q - BLEN_WIDTH'(1)));
    assign is_read_cmd  = (m_cmd == CMD_RD) || (m_cmd == CMD_RDEX) || (m_cmd == CMD_RDL);
    assign mem_we       = (state_q == ST_WDATA) && m_data_valid && !seq_err_q;
    assign s_cmd_accept = (state_q == ST_IDLE);

    // Control registers: state, latched request fields and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            tag_q      <= '0;
            seq_err_q  <= 1'b0;
            last_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            tag_q      <= tag_d;
            seq_err_q  <= seq_err_d;
            last_err_q <= last_err_d;
        end
    end

    // Memory array: cleared on reset, byte-merged on each accepted write beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (m_data_byteen[b]) begin
                    mem_q[cur_addr][8*b +: 8] <= m_data[8*b +: 8];
                end
            end
        end
    end

    // Next-state logic: command capture, beat counting and error tracking.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        tag_d      = tag_q;
        seq_err_d  = seq_err_q;
        last_err_d = last_err_q;
        case (state_q)
            ST_IDLE: begin
                if (m_cmd != CMD_IDLE) begin
                    cmd_d      = m_cmd;
                    addr_d     = m_addr;
                    len_d      = (m_burst_length == '0) ? BLEN_WIDTH'(1) : m_burst_length;
                    tag_d      = m_tagid;
                    seq_err_d  = (m_burst_seq != 3'b000);
                    beat_d     = '0;
                    last_err_d = 1'b0;
                    state_d    = is_read_cmd ? ST_RRESP : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (m_data_valid) begin
                    beat_d = beat_q + BLEN_WIDTH'(1);
                    if (m_data_last != is_last) begin
                        last_err_d = 1'b1;
                    end
                    if (is_last) begin
                        // Plain WR is posted and never gets a response.
                        state_d = (cmd_q == CMD_WR) ? ST_IDLE : ST_WRESP;
                    end
                end
            end
            ST_RRESP: begin
                if (m_resp_accept) begin
                    beat_d = beat_q + BLEN_WIDTH'(1);
                    if (is_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRESP: begin
                if (m_resp_accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response outputs depend only on registered state, so they hold while stalled.
    always_comb begin
        s_data_accept = 1'b0;
        s_resp        = RESP_NULL;
        s_data        = '0;
        s_resp_last   = 1'b0;
        s_tagid       = '0;
        case (state_q)
            ST_WDATA: begin
                s_data_accept = 1'b1;
            end
            ST_RRESP: begin
                s_resp      = seq_err_q ? RESP_ERR : RESP_DVA;
                s_data      = seq_err_q ? '0 : mem_q[cur_addr];
                s_resp_last = is_last;
                s_tagid     = tag_q;
            end
            ST_WRESP: begin
                s_resp      = (seq_err_q || last_err_q) ? RESP_ERR : RESP_DVA;
                s_resp_last = 1'b1;
                s_tagid     = tag_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Bench for ocp_slave_mem: directed scenarios plus randomized bursts, all
// checked against a plain word-array model of the memory.
module tb_ocp_slave_mem;

    localparam logic [2:0] C_WR   = 3'b001;
    localparam logic [2:0] C_RD   = 3'b010;
    localparam logic [2:0] C_RDEX = 3'b011;
    localparam logic [2:0] C_RDL  = 3'b100;
    localparam logic [2:0] C_WRNP = 3'b101;
    localparam logic [2:0] C_WRC  = 3'b110;
    localparam logic [2:0] C_BCST = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  m_cmd = '0;
    logic [4:0]  m_addr = '0;
    logic [3:0]  m_burst_length = '0;
    logic [2:0]  m_burst_seq = '0;
    logic [3:0]  m_byteen = '0;
    logic [4:0]  m_tagid = '0;
    logic [3:0]  m_req_info = '0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_data_byteen = '0;
    logic        m_data_last = 1'b0;
    logic [4:0]  m_data_tagid = '0;
    logic        m_data_valid = 1'b0;
    logic        m_resp_accept = 1'b0;
    logic        s_cmd_accept;
    logic        s_data_accept;
    logic [31:0] s_data;
    logic [1:0]  s_resp;
    logic        s_resp_last;
    logic [4:0]  s_tagid;

    logic [31:0] model [32];
    logic [31:0] wd [16];
    logic [3:0]  wb [16];
    int          errors = 0;
    int          checks = 0;

    ocp_slave_mem dut (
        .clk(clk), .rst(rst), .m_cmd(m_cmd), .m_addr(m_addr),
        .m_burst_length(m_burst_length), .m_burst_seq(m_burst_seq),
        .m_byteen(m_byteen), .m_tagid(m_tagid), .m_req_info(m_req_info),
        .m_data(m_data), .m_data_byteen(m_data_byteen), .m_data_last(m_data_last),
        .m_data_tagid(m_data_tagid), .m_data_valid(m_data_valid),
        .m_resp_accept(m_resp_accept), .s_cmd_accept(s_cmd_accept),
        .s_data_accept(s_data_accept), .s_data(s_data), .s_resp(s_resp),
        .s_resp_last(s_resp_last), .s_tagid(s_tagid)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [4:0] addr, input logic [3:0] blen,
                         input logic [2:0] seq, input logic [4:0] tag);
        checks++;
        if (s_cmd_accept !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept got=%0b exp=1", s_cmd_accept);
        end
        m_cmd = cmd; m_addr = addr; m_burst_length = blen; m_burst_seq = seq; m_tagid = tag;
        m_byteen = 4'($urandom); m_req_info = 4'($urandom);
        cycle();
        m_cmd = '0; m_addr = '0; m_burst_length = '0; m_burst_seq = '0; m_tagid = '0;
    endtask

    task automatic write_burst(input logic [2:0] cmd, input logic [4:0] addr, input logic [3:0] blen,
                               input logic [2:0] seq, input logic [4:0] tag, input int last_pos,
                               input bit stalls);
        int L;
        int k;
        bit exp_err;
        logic [4:0] a;
        L = (blen == 0) ? 1 : int'(blen);
        exp_err = (seq != 0) || (last_pos != L - 1);
        issue(cmd, addr, blen, seq, tag);
        for (int b = 0; b < L; b++) begin
            k = stalls ? int'($urandom_range(0, 1)) : 0;
            repeat (k) begin
                m_data_valid = 1'b0;
                checks++;
                if (s_data_accept !== 1'b1 || s_resp !== 2'b00) begin
                    errors++;
                    $display("FAIL wstall beat=%0d accept=%0b resp=%0d exp accept=1 resp=0", b, s_data_accept, s_resp);
                end
                cycle();
            end
            checks++;
            if (s_data_accept !== 1'b1) begin
                errors++;
                $display("FAIL data_accept beat=%0d got=%0b exp=1", b, s_data_accept);
            end
            m_data_valid = 1'b1; m_data = wd[b]; m_data_byteen = wb[b];
            m_data_last = (b == last_pos); m_data_tagid = 5'($urandom);
            cycle();
            m_data_valid = 1'b0; m_data_last = 1'b0;
            if (seq == 0) begin
                a = addr + 5'(b);
                for (int i = 0; i < 4; i++) begin
                    if (wb[b][i]) model[a][8*i +: 8] = wd[b][8*i +: 8];
                end
            end
        end
        if (cmd == C_WR) begin
            checks++;
            if (s_resp !== 2'b00 || s_cmd_accept !== 1'b1 || s_data_accept !== 1'b0) begin
                errors++;
                $display("FAIL posted_wr resp=%0d cmd_acc=%0b data_acc=%0b exp 0/1/0", s_resp, s_cmd_accept, s_data_accept);
            end
        end else begin
            k = stalls ? int'($urandom_range(0, 3)) : 0;
            for (int c = 0; c <= k; c++) begin
                m_resp_accept = (c == k);
                checks++;
                if ({s_resp, s_resp_last, s_tagid, s_data} !== {(exp_err ? 2'b11 : 2'b01), 1'b1, tag, 32'h0}) begin
                    errors++;
                    $display("FAIL wresp resp=%0d last=%0b tag=%0d data=%h exp resp=%0d last=1 tag=%0d data=0",
                             s_resp, s_resp_last, s_tagid, s_data, exp_err ? 3 : 1, tag);
                end
                cycle();
            end
            m_resp_accept = 1'b0;
            checks++;
            if (s_resp !== 2'b00 || s_cmd_accept !== 1'b1) begin
                errors++;
                $display("FAIL wresp_done resp=%0d cmd_acc=%0b exp 0/1", s_resp, s_cmd_accept);
            end
        end
    endtask

    // stall >= 0: fixed hold cycles per beat; stall < 0: random 0..2
    task automatic read_burst(input logic [2:0] cmd, input logic [4:0] addr, input logic [3:0] blen,
                              input logic [2:0] seq, input logic [4:0] tag, input int stall);
        int L;
        int k;
        logic [4:0] a;
        logic [31:0] ed;
        logic [1:0] er;
        L = (blen == 0) ? 1 : int'(blen);
        issue(cmd, addr, blen, seq, tag);
        for (int b = 0; b < L; b++) begin
            a  = addr + 5'(b);
            ed = (seq != 0) ? 32'h0 : model[a];
            er = (seq != 0) ? 2'b11 : 2'b01;
            k  = (stall >= 0) ? stall : int'($urandom_range(0, 2));
            for (int c = 0; c <= k; c++) begin
                m_resp_accept = (c == k);
                checks++;
                if ({s_resp, s_data, s_resp_last, s_tagid} !== {er, ed, (b == L - 1), tag}) begin
                    errors++;
                    $display("FAIL rbeat a=%0d b=%0d resp=%0d data=%h last=%0b tag=%0d exp resp=%0d data=%h last=%0b tag=%0d",
                             addr, b, s_resp, s_data, s_resp_last, s_tagid, er, ed, (b == L - 1), tag);
                end
                cycle();
            end
        end
        m_resp_accept = 1'b0;
        checks++;
        if (s_resp !== 2'b00 || s_cmd_accept !== 1'b1 || s_data !== 32'h0) begin
            errors++;
            $display("FAIL rdone resp=%0d cmd_acc=%0b data=%h exp 0/1/0", s_resp, s_cmd_accept, s_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        checks++;
        if ({s_cmd_accept, s_data_accept, s_resp, s_data, s_resp_last, s_tagid} !== {1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 5'h0}) begin
            errors++;
            $display("FAIL reset_outputs cmd_acc=%0b data_acc=%0b resp=%0d data=%h last=%0b tag=%0d exp 1/0/0/0/0/0",
                     s_cmd_accept, s_data_accept, s_resp, s_data, s_resp_last, s_tagid);
        end
        read_burst(C_RD, 5'd0, 4'd15, 3'b000, 5'd1, 0);
        read_burst(C_RDEX, 5'd15, 4'd0, 3'b000, 5'd2, 0);
        read_burst(C_RDL, 5'd16, 4'd15, 3'b000, 5'd3, 0);
        read_burst(C_RD, 5'd31, 4'd1, 3'b000, 5'd4, 0);
    endtask

    task automatic test_wrnp_rd();
        wd[0] = 32'hAAAA_0001; wb[0] = 4'hF;
        wd[1] = 32'hAAAA_0002; wb[1] = 4'hF;
        write_burst(C_WRNP, 5'd3, 4'd2, 3'b000, 5'd5, 1, 1'b0);
        read_burst(C_RD, 5'd3, 4'd2, 3'b000, 5'd7, 3);
        read_burst(C_RD, 5'd3, 4'd2, 3'b000, 5'd9, 0);
    endtask

    task automatic test_wrap();
        wd[0] = 32'h11; wb[0] = 4'hF;
        wd[1] = 32'h22; wb[1] = 4'hF;
        write_burst(C_WR, 5'd31, 4'd2, 3'b000, 5'd6, 1, 1'b0);
        read_burst(C_RD, 5'd31, 4'd2, 3'b000, 5'd8, 0);
    endtask

    task automatic test_errors();
        wd[0] = 32'hCAFE_0001; wb[0] = 4'hF;
        wd[1] = 32'hCAFE_0002; wb[1] = 4'hF;
        write_burst(C_WRC, 5'd10, 4'd2, 3'b000, 5'd11, 0, 1'b0);
        read_burst(C_RD, 5'd10, 4'd2, 3'b001, 5'd12, 1);
        wd[0] = 32'h5555_5555; wb[0] = 4'hF;
        write_burst(C_WRNP, 5'd10, 4'd1, 3'b010, 5'd13, 0, 1'b0);
        write_burst(C_BCST, 5'd20, 4'd1, 3'b000, 5'd14, 5, 1'b0);
        read_burst(C_RD, 5'd10, 4'd2, 3'b000, 5'd15, 0);
        read_burst(C_RD, 5'd20, 4'd1, 3'b000, 5'd16, 0);
    endtask

    task automatic test_byteen();
        wd[0] = 32'h1234_5678; wb[0] = 4'hF;
        write_burst(C_WR, 5'd9, 4'd1, 3'b000, 5'd17, 0, 1'b0);
        wd[0] = 32'hDEAD_BEEF; wb[0] = 4'b0011;
        write_burst(C_WR, 5'd9, 4'd1, 3'b000, 5'd18, 0, 1'b0);
        checks++;
        if (model[9] !== 32'h1234_BEEF) begin
            errors++;
            $display("FAIL byteen_model got=%h exp=1234beef", model[9]);
        end
        read_burst(C_RD, 5'd9, 4'd1, 3'b000, 5'd19, 0);
    endtask

    task automatic test_random();
        logic [2:0] cmd;
        logic [2:0] seq;
        logic [3:0] blen;
        int L;
        int lp;
        for (int n = 0; n < 40; n++) begin
            cmd  = 3'($urandom_range(1, 7));
            blen = 4'($urandom);
            seq  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            L    = (blen == 0) ? 1 : int'(blen);
            if (cmd == C_RD || cmd == C_RDEX || cmd == C_RDL) begin
                read_burst(cmd, 5'($urandom), blen, seq, 5'($urandom), -1);
            end else begin
                for (int b = 0; b < 16; b++) begin
                    wd[b] = $urandom;
                    wb[b] = 4'($urandom);
                end
                lp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : L - 1;
                write_burst(cmd, 5'($urandom), blen, seq, 5'($urandom), lp, 1'b1);
            end
        end
        for (int a = 0; a < 32; a += 8) begin
            read_burst(C_RD, 5'(a), 4'd8, 3'b000, 5'(a), 0);
        end
    endtask

    task automatic test_reset_midburst();
        issue(C_RD, 5'd3, 4'd4, 3'b000, 5'd21);
        m_resp_accept = 1'b1;
        checks++;
        if (s_resp !== 2'b01 || s_data !== model[3]) begin
            errors++;
            $display("FAIL mid_beat1 resp=%0d data=%h exp resp=1 data=%h", s_resp, s_data, model[3]);
        end
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        m_resp_accept = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        checks++;
        if (s_resp !== 2'b00 || s_cmd_accept !== 1'b1 || s_data !== 32'h0 || s_tagid !== 5'h0) begin
            errors++;
            $display("FAIL mid_reset resp=%0d cmd_acc=%0b data=%h tag=%0d exp 0/1/0/0", s_resp, s_cmd_accept, s_data, s_tagid);
        end
        cycle();
        checks++;
        if (s_resp !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_quiet resp=%0d exp=0", s_resp);
        end
        read_burst(C_RD, 5'd3, 4'd2, 3'b000, 5'd22, 0);
        read_burst(C_RD, 5'($urandom), 4'd4, 3'b000, 5'd23, 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_wrnp_rd();
        test_wrap();
        test_errors();
        test_byteen();
        test_random();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
